// File: rtl/hazard_scoreboard_ctrl.sv
// hazard_scoreboard_ctrl: 5-stage hazard controller with a multi-cycle-unit register scoreboard.
// Optional perf counters are enabled with `define HAZARD_PERF_EN.
module hazard_scoreboard_ctrl #(
    parameter int DWIDTH = 32,
    parameter int NREG   = 32,
    parameter int RID_W  = $clog2(NREG),
    parameter int LAT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RID_W-1:0]  id_rs1_id,
    input  logic [RID_W-1:0]  id_rs2_id,
    input  logic [RID_W-1:0]  id_rdst_id,
    input  logic              id_we,
    input  logic              id_mc_valid,
    input  logic [LAT_W-1:0]  id_mc_lat,
    input  logic [RID_W-1:0]  ex_rdst_id,
    input  logic              ex_re_dmem,
    input  logic              ex_jump_valid,
    input  logic [DWIDTH-1:0] if_pc,
    input  logic [DWIDTH-1:0] id_pc,
    input  logic [DWIDTH-1:0] ex_jpc,
    input  logic              mem_wait,
    output logic [1:0]        if_ctrl,
    output logic [1:0]        id_ctrl,
    output logic [1:0]        ex_ctrl,
    output logic [1:0]        mem_ctrl,
    output logic [1:0]        wb_ctrl,
    output logic              data_hazard,
    output logic              struct_hazard,
    output logic              control_hazard,
    output logic              mc_issue,
`ifdef HAZARD_PERF_EN
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt,
    output logic [31:0]       perf_mc_cnt,
`endif
    output logic [NREG-1:0]   rf_busy
);
    localparam logic [1:0] C_PIPE = 2'd0, C_STALL = 2'd1, C_FLUSH = 2'd2, C_JUMP = 2'd3;

    logic [LAT_W-1:0] r_cnt [NREG];
    logic [LAT_W-1:0] r_unit_cnt;
    logic [NREG-1:0]  w_busy;
    logic [LAT_W-1:0] w_lat;
    logic             w_load_use, w_raw, w_waw, w_dh, w_sh, w_ch, w_bypass;
    logic [9:0]       w_ctrl;

    always_comb begin
        w_busy = '0;
        for (int r = 1; r < NREG; r++) w_busy[r] = r_cnt[r] != '0;
    end

    assign w_lat      = (id_mc_lat == '0) ? LAT_W'(1) : id_mc_lat;
    assign w_load_use = ex_re_dmem && ((id_rs1_id != '0 && id_rs1_id == ex_rdst_id) ||
                                       (id_rs2_id != '0 && id_rs2_id == ex_rdst_id));
    assign w_raw      = w_busy[id_rs1_id] || w_busy[id_rs2_id];
    assign w_waw      = id_we && w_busy[id_rdst_id];
    assign w_dh       = w_load_use || w_raw || w_waw;
    assign w_sh       = id_mc_valid && r_unit_cnt != '0;
    assign w_ch       = ex_jump_valid && ex_jpc != id_pc;
    assign w_bypass   = ex_jpc == if_pc;

    // mem_wait outranks the jump, so a pending redirect simply re-evaluates once memory is ready
    assign w_ctrl = rst         ? {C_FLUSH, C_FLUSH, C_FLUSH, C_FLUSH, C_PIPE} :
                    mem_wait    ? {C_STALL, C_STALL, C_STALL, C_STALL, C_FLUSH} :
                    w_ch        ? {w_bypass ? C_PIPE : C_JUMP, w_bypass ? C_PIPE : C_FLUSH, C_FLUSH, C_PIPE, C_PIPE} :
                    w_dh | w_sh ? {C_STALL, C_STALL, C_FLUSH, C_PIPE, C_PIPE} :
                                  {5{C_PIPE}};
    assign {if_ctrl, id_ctrl, ex_ctrl, mem_ctrl, wb_ctrl} = w_ctrl;

    assign data_hazard    = !rst && w_dh;
    assign struct_hazard  = !rst && w_sh;
    assign control_hazard = !rst && w_ch;
    assign mc_issue       = id_mc_valid && ex_ctrl == C_PIPE && id_ctrl == C_PIPE && !rst && !mem_wait;
    assign rf_busy        = w_busy;

    // the unit runs on its own write port, so counters keep draining through mem_wait
    always_ff @(posedge clk) begin
        r_cnt[0] <= '0;
        for (int r = 1; r < NREG; r++) begin
            if (rst)
                r_cnt[r] <= '0;
            else if (mc_issue && id_we && id_rdst_id == RID_W'(r))
                r_cnt[r] <= w_lat;
            else if (r_cnt[r] != '0)
                r_cnt[r] <= r_cnt[r] - LAT_W'(1);
        end
        if (rst)
            r_unit_cnt <= '0;
        else if (mc_issue)
            r_unit_cnt <= w_lat;
        else if (r_unit_cnt != '0)
            r_unit_cnt <= r_unit_cnt - LAT_W'(1);
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_stall, r_perf_flush, r_perf_mc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
            r_perf_mc    <= '0;
        end else begin
            if (w_dh || w_sh || mem_wait) r_perf_stall <= r_perf_stall + 32'd1;
            if (w_ch && !w_bypass)        r_perf_flush <= r_perf_flush + 32'd1;
            if (mc_issue)                 r_perf_mc    <= r_perf_mc + 32'd1;
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
    assign perf_mc_cnt    = r_perf_mc;
`endif
endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// tb_hazard_scoreboard_ctrl: directed bench with a per-register countdown model checked every cycle.
module tb_hazard_scoreboard_ctrl;
    localparam int NREG = 32;

    logic        clk = 0;
    logic        rst;
    logic [4:0]  rs1, rs2, rd, exrd;
    logic        we, mcv, exre, jv, mw;
    logic [3:0]  lat;
    logic [31:0] ifpc, idpc, jpc;
    logic [1:0]  if_c, id_c, ex_c, mem_c, wb_c;
    logic        dh, sh, ch, issue;
    logic [31:0] busy;
`ifdef HAZARD_PERF_EN
    logic [31:0] p_stall, p_flush, p_mc;
`endif

    hazard_scoreboard_ctrl dut (
        .clk(clk), .rst(rst), .id_rs1_id(rs1), .id_rs2_id(rs2), .id_rdst_id(rd), .id_we(we),
        .id_mc_valid(mcv), .id_mc_lat(lat), .ex_rdst_id(exrd), .ex_re_dmem(exre),
        .ex_jump_valid(jv), .if_pc(ifpc), .id_pc(idpc), .ex_jpc(jpc), .mem_wait(mw),
        .if_ctrl(if_c), .id_ctrl(id_c), .ex_ctrl(ex_c), .mem_ctrl(mem_c), .wb_ctrl(wb_c),
        .data_hazard(dh), .struct_hazard(sh), .control_hazard(ch), .mc_issue(issue),
`ifdef HAZARD_PERF_EN
        .perf_stall_cnt(p_stall), .perf_flush_cnt(p_flush), .perf_mc_cnt(p_mc),
`endif
        .rf_busy(busy)
    );

    always #5 clk = ~clk;

    int m_cnt [NREG];
    int m_unit;
    bit e_issue;
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic idle();
        rst = 0; rs1 = 0; rs2 = 0; rd = 0; exrd = 0; we = 0; mcv = 0; exre = 0; jv = 0; mw = 0;
        lat = 0; ifpc = 32'h104; idpc = 32'h100; jpc = 32'h0;
    endtask

    // Model expectations at the negedge, from the rule text and the countdown array
    task automatic eval();
        bit lu, raw, waw, edh, esh, ech, bp;
        logic [1:0] e [5];
        logic [31:0] eb;
        @(negedge clk);
        lu  = exre && ((rs1 != 0 && rs1 == exrd) || (rs2 != 0 && rs2 == exrd));
        raw = (rs1 != 0 && m_cnt[rs1] > 0) || (rs2 != 0 && m_cnt[rs2] > 0);
        waw = we && rd != 0 && m_cnt[rd] > 0;
        edh = !rst && (lu || raw || waw);
        esh = !rst && mcv && m_unit > 0;
        ech = !rst && jv && jpc != idpc;
        bp  = jpc == ifpc;
        if (rst)             e = '{2, 2, 2, 2, 0};
        else if (mw)         e = '{1, 1, 1, 1, 2};
        else if (ech)        e = bp ? '{0, 0, 2, 0, 0} : '{3, 2, 2, 0, 0};
        else if (edh || esh) e = '{1, 1, 2, 0, 0};
        else                 e = '{0, 0, 0, 0, 0};
        e_issue = !rst && !mw && mcv && e[1] == 0 && e[2] == 0;
        eb = 0;
        for (int r = 1; r < NREG; r++) eb[r] = m_cnt[r] > 0;
        chk("if_ctrl", 32'(if_c), 32'(e[0]));
        chk("id_ctrl", 32'(id_c), 32'(e[1]));
        chk("ex_ctrl", 32'(ex_c), 32'(e[2]));
        chk("mem_ctrl", 32'(mem_c), 32'(e[3]));
        chk("wb_ctrl", 32'(wb_c), 32'(e[4]));
        chk("data_hazard", 32'(dh), 32'(edh));
        chk("struct_hazard", 32'(sh), 32'(esh));
        chk("control_hazard", 32'(ch), 32'(ech));
        chk("mc_issue", 32'(issue), 32'(e_issue));
        chk("rf_busy", busy, eb);
    endtask

    task automatic adv();
        int l;
        @(posedge clk);
        l = (lat == 0) ? 1 : int'(lat);
        for (int r = 0; r < NREG; r++) m_cnt[r] = rst ? 0 : (m_cnt[r] > 0 ? m_cnt[r] - 1 : 0);
        if (!rst && e_issue && we && rd != 0) m_cnt[rd] = l;
        m_unit = rst ? 0 : e_issue ? l : (m_unit > 0 ? m_unit - 1 : 0);
        #1;
    endtask

    task automatic issue_mc(input logic [4:0] r, input logic [3:0] l);
        idle(); mcv = 1; we = 1; rd = r; lat = l;
        eval(); chk("lit_issue", 32'(issue), 1);
        adv();
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
        m_unit = 0;
        idle(); rst = 1;
        eval(); chk("lit_rst_if", 32'(if_c), 2); chk("lit_rst_wb", 32'(wb_c), 0);
        adv(); adv();
        // load-use
        idle(); exre = 1; exrd = 5; rs2 = 5;
        eval(); chk("lit_lu_dh", 32'(dh), 1); chk("lit_lu_id", 32'(id_c), 1); chk("lit_lu_ex", 32'(ex_c), 2);
        adv();
        idle(); exre = 1; exrd = 0;
        eval(); chk("lit_lu_x0", 32'(dh), 0);
        adv();
        // multi-cycle RAW, lat 4: four stalls then pipe
        issue_mc(7, 4);
        idle(); rs1 = 7;
        for (int k = 0; k < 4; k++) begin
            eval(); chk("lit_raw_stall", 32'(id_c), 1); chk("lit_raw_busy", 32'(busy[7]), 1);
            adv();
        end
        eval(); chk("lit_raw_go", 32'(id_c), 0); chk("lit_raw_free", 32'(busy[7]), 0);
        adv();
        // structural: unit busy for 3 cycles
        issue_mc(8, 3);
        idle(); mcv = 1; we = 1; rd = 9; lat = 2;
        for (int k = 0; k < 3; k++) begin
            eval(); chk("lit_struct", 32'(sh), 1); chk("lit_struct_noiss", 32'(issue), 0);
            adv();
        end
        eval(); chk("lit_struct_clr", 32'(sh), 0); chk("lit_struct_iss", 32'(issue), 1);
        adv();
        // WAW on busy x9
        idle(); we = 1; rd = 9;
        eval(); chk("lit_waw", 32'(dh), 1);
        adv();
        idle(); eval(); adv(); eval(); adv();
        // zero latency counts as one
        issue_mc(10, 0);
        idle(); rs1 = 10;
        eval(); chk("lit_lat0_busy", 32'(dh), 1);
        adv();
        eval(); chk("lit_lat0_free", 32'(dh), 0);
        adv();
        // jumps
        idle(); jv = 1; jpc = 32'h40; idpc = 32'h10; ifpc = 32'h14;
        eval(); chk("lit_jmp_if", 32'(if_c), 3); chk("lit_jmp_id", 32'(id_c), 2); chk("lit_jmp_ex", 32'(ex_c), 2);
        adv();
        ifpc = 32'h40;
        eval(); chk("lit_byp_if", 32'(if_c), 0); chk("lit_byp_id", 32'(id_c), 0); chk("lit_byp_ex", 32'(ex_c), 2);
        adv();
        idpc = 32'h40;
        eval(); chk("lit_jmp_same", 32'(ch), 0);
        adv();
        // mem_wait over a jump and busy x3
        issue_mc(3, 2);
        idle(); mw = 1; jv = 1; jpc = 32'h40; idpc = 32'h10; ifpc = 32'h14; rs1 = 3; mcv = 1; lat = 1;
        eval(); chk("lit_mw_if", 32'(if_c), 1); chk("lit_mw_mem", 32'(mem_c), 1); chk("lit_mw_wb", 32'(wb_c), 2);
        adv(); eval(); adv();
        eval(); chk("lit_mw_drain", 32'(busy[3]), 0);
        adv();
        mw = 0; mcv = 0;
        eval(); chk("lit_mw_jump", 32'(if_c), 3);
        adv();
        // reset mid-countdown
        issue_mc(9, 5);
        idle(); eval(); adv();
        rst = 1;
        eval(); chk("lit_rst_id", 32'(id_c), 2); chk("lit_rst_mem", 32'(mem_c), 2);
        adv();
        idle(); mcv = 1; we = 1; rd = 9; lat = 1;
        eval(); chk("lit_rst_busy", busy, 0); chk("lit_rst_unit", 32'(issue), 1);
`ifdef HAZARD_PERF_EN
        chk("lit_perf_stall", p_stall, 0); chk("lit_perf_flush", p_flush, 0); chk("lit_perf_mc", p_mc, 0);
`endif
        adv();
        idle(); eval(); adv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard_ctrl.md
Name: hazard_scoreboard_ctrl

Overview:
- Parametrised successor to the 5-stage pipeline hazard controller.
- Keeps the existing load-use detection and EX-resolved jump handling.
- Adds a per-register scoreboard for a non-pipelined multi-cycle unit (div/mul) with programmable latency, structural and WAW stalls, and a global memory-wait freeze.
- Drives the 2-bit stage controls for IF, ID, EX, MEM and WB; sits beside the pipeline registers.

Parameters:
- DWIDTH, 32, PC width.
- NREG, 32, architectural register count; reg 0 is hardwired zero.
- RID_W, $clog2(NREG), register index width.
- LAT_W, 4, width of the multi-cycle latency and counters; max latency 2^LAT_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- id_rs1_id, id_rs2_id  in  RID_W  ID source registers.
- id_rdst_id  in  RID_W  ID destination register.
- id_we  in  1  ID instruction writes id_rdst_id.
- id_mc_valid  in  1  ID instruction is a multi-cycle op.
- id_mc_lat  in  LAT_W  its latency in cycles; 0 is treated as 1.
- ex_rdst_id  in  RID_W  EX destination register.
- ex_re_dmem  in  1  EX instruction is a load.
- ex_jump_valid  in  1  EX holds a resolved jump or branch.
- if_pc, id_pc, ex_jpc  in  DWIDTH  PCs; ex_jpc is the resolved next PC.
- mem_wait  in  1  data memory not ready.
- if_ctrl, id_ctrl, ex_ctrl, mem_ctrl, wb_ctrl  out  2 each  stage controls: C_PIPE=0, C_STALL=1, C_FLUSH=2, C_JUMP=3.
- data_hazard, struct_hazard, control_hazard  out  1 each  hazard flags.
- mc_issue  out  1  multi-cycle op advances ID->EX this cycle.
- rf_busy  out  NREG  scoreboard busy vector.

Behaviour:
- State:
  - cnt[r], LAT_W bits, for r=1..NREG-1; cnt[0] is constant 0. busy[r] = (cnt[r]!=0).
  - unit_cnt, LAT_W bits.
- Reset (rst=1 at clk edge): all cnt and unit_cnt clear to 0. While rst=1: if/id/ex/mem_ctrl=C_FLUSH, wb_ctrl=C_PIPE, all hazard flags 0, mc_issue=0.
- Hazard terms (combinational):
  - load_use = ex_re_dmem and a nonzero id_rsN_id equal to ex_rdst_id.
  - raw = nonzero id_rsN_id with busy set.
  - waw = id_we, id_rdst_id!=0, busy[id_rdst_id].
  - data_hazard = load_use | raw | waw.
  - struct_hazard = id_mc_valid & (unit_cnt!=0).
  - control_hazard = ex_jump_valid & (ex_jpc != id_pc).
  - bypass = (ex_jpc == if_pc).
- Priority: rst > mem_wait > control_hazard > data/struct hazard > normal.
- mem_wait=1:
  - if/id/ex/mem_ctrl=C_STALL, wb_ctrl=C_FLUSH.
  - Control hazard is deferred; it is re-evaluated when mem_wait drops.
- control_hazard:
  - bypass=1: if_ctrl=C_PIPE, id_ctrl=C_PIPE.
  - bypass=0: if_ctrl=C_JUMP, id_ctrl=C_FLUSH.
  - In both cases ex_ctrl=C_FLUSH, mem_ctrl=C_PIPE, wb_ctrl=C_PIPE.
- data_hazard or struct_hazard: if_ctrl=id_ctrl=C_STALL, ex_ctrl=C_FLUSH (bubble), mem_ctrl=wb_ctrl=C_PIPE.
- Otherwise all stage controls are C_PIPE.
- mc_issue = id_mc_valid & ex_ctrl==C_PIPE & id_ctrl==C_PIPE & !rst & !mem_wait.
- Scoreboard update, every clk when not in reset:
  - Each nonzero cnt decrements by 1. This includes during mem_wait; the unit runs autonomously and writes back on its own port.
  - On mc_issue with id_we and id_rdst_id!=0: cnt[id_rdst_id] loads max(id_mc_lat,1). A load wins over a decrement in the same cycle.
  - On mc_issue: unit_cnt loads max(id_mc_lat,1); otherwise a nonzero unit_cnt decrements.
  - Counters saturate at 0 and never wrap.
- Latency:
  - rf_busy reflects a load one cycle after mc_issue.
  - A dependent instruction leaves ID in the cycle after its cnt reaches 0.
- Simultaneous load_use and raw: treated as a single stall.
- Control hazard with a pending multi-cycle op: the op is not cancelled (it already issued); only younger stages are flushed.

Optional Feature:
HAZARD_PERF_EN:
- Defined: adds outputs perf_stall_cnt, perf_flush_cnt and perf_mc_cnt (32 bits each).
  - perf_stall_cnt increments on each cycle with data_hazard|struct_hazard|mem_wait.
  - perf_flush_cnt increments on each control_hazard cycle with bypass=0.
  - perf_mc_cnt increments on each mc_issue.
  - All clear on rst and wrap at 2^32.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Load-use: ex_re_dmem=1, ex_rdst_id=5, id_rs2_id=5 -> data_hazard=1, if/id=C_STALL, ex=C_FLUSH for 1 cycle.
- Multi-cycle RAW: issue div rd=7, lat=4; next ID reads x7 -> rf_busy[7]=1; ID stalls 4 cycles; C_PIPE on cycle 5; cnt[7] sequence 4,3,2,1,0.
- Structural and WAW:
  - Second mc op while unit_cnt=3 -> struct_hazard=1 until unit_cnt=0.
  - ID write to busy x7 -> data_hazard=1.
- Jump: ex_jump_valid=1, ex_jpc=0x40, id_pc=0x10, if_pc=0x14 -> if=C_JUMP, id=C_FLUSH, ex=C_FLUSH. Same with if_pc=0x40 -> if/id=C_PIPE.
- mem_wait=1 concurrent with jump and a busy x3 (cnt=2) -> all C_STALL, wb=C_FLUSH; cnt[3] still reaches 0; jump handled the cycle after mem_wait=0.
- rst asserted mid-countdown (cnt[9]=5) -> after edge all cnt=0, rf_busy=0, controls C_FLUSH (wb C_PIPE); perf counters 0 when HAZARD_PERF_EN.
